// File: rtl/mkgauss_ctrl.sv
// Sequencer feeding the mkgauss discrete-Gaussian sampler: fetches PRNG words,
// issues paired r1/r2 beats, captures each sample and writes it to the coefficient RAM.
module mkgauss_ctrl #(
  parameter int unsigned LOGN_MAX = 10,
  parameter int unsigned TIMEOUT  = 2000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [3:0]          logn,
  input  logic                prng_valid,
  input  logic [63:0]         prng_data,
  output logic                prng_ready,
  output logic                r1_valid,
  output logic                r2_valid,
  output logic [63:0]         r1,
  output logic [63:0]         r2,
  input  logic                val_valid,
  input  logic signed [31:0]  val,
  output logic                smp_we,
  output logic [LOGN_MAX-1:0] smp_addr,
  output logic [31:0]         smp_data,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned AW = LOGN_MAX;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned WW = 64;
  localparam int unsigned DW = 32;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_ISSUE_A, S_GAP, S_ISSUE_B, S_WAIT, S_WRITE, S_DRAIN, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           wcnt_q, wcnt_d;
  logic [3:0][WW-1:0]   wbuf_q, wbuf_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        last_q, last_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic                 err_q, err_d;

  logic                 prng_ready_q, prng_ready_d;
  logic                 strb_q, strb_d;
  logic [WW-1:0]        r1_q, r1_d, r2_q, r2_d;
  logic                 smp_we_q, smp_we_d;
  logic [AW-1:0]        smp_addr_q, smp_addr_d;
  logic [DW-1:0]        smp_data_q, smp_data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [3:0]           lg_c;
  logic [AW:0]          n_c;

  // Next-state logic; outputs are derived from the next state so they register in step with it.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    wbuf_d     = wbuf_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    tmr_d      = tmr_q;
    err_d      = err_q;
    smp_data_d = '0;

    lg_c = (logn > 4'(LOGN_MAX)) ? 4'(LOGN_MAX) : logn;
    n_c  = (AW + 1)'(1) << lg_c;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          last_d  = AW'(n_c - (AW + 1)'(1));
          cnt_d   = '0;
          wcnt_d  = '0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (prng_valid && prng_ready_q) begin
          wbuf_d[wcnt_q] = prng_data;
          wcnt_d         = wcnt_q + 2'd1;
          if (wcnt_q == 2'd3) state_d = S_ISSUE_A;
        end
      end
      S_ISSUE_A, S_GAP, S_ISSUE_B: begin
        // Any sample arriving before both beats are out is a protocol violation.
        if (val_valid) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          case (state_q)
            S_ISSUE_A: state_d = S_GAP;
            S_GAP:     state_d = S_ISSUE_B;
            default: begin
              tmr_d   = '0;
              state_d = S_WAIT;
            end
          endcase
        end
      end
      S_WAIT: begin
        if (val_valid) begin
          smp_data_d = $unsigned(val);
          state_d    = S_WRITE;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_WRITE: state_d = S_DRAIN;
      S_DRAIN: begin
        if (!val_valid) begin
          if (cnt_q == last_q) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + AW'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    prng_ready_d = (state_d == S_FETCH);
    strb_d       = (state_d == S_ISSUE_A) || (state_d == S_ISSUE_B);
    r1_d         = (state_d == S_ISSUE_A) ? wbuf_d[0] :
                   (state_d == S_ISSUE_B) ? wbuf_d[2] : '0;
    r2_d         = (state_d == S_ISSUE_A) ? wbuf_d[1] :
                   (state_d == S_ISSUE_B) ? wbuf_d[3] : '0;
    smp_we_d     = (state_d == S_WRITE);
    smp_addr_d   = (state_d == S_WRITE) ? cnt_d : '0;
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wcnt_q       <= '0;
      wbuf_q       <= '0;
      cnt_q        <= '0;
      last_q       <= '0;
      tmr_q        <= '0;
      err_q        <= 1'b0;
      prng_ready_q <= 1'b0;
      strb_q       <= 1'b0;
      r1_q         <= '0;
      r2_q         <= '0;
      smp_we_q     <= 1'b0;
      smp_addr_q   <= '0;
      smp_data_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      wbuf_q       <= wbuf_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      tmr_q        <= tmr_d;
      err_q        <= err_d;
      prng_ready_q <= prng_ready_d;
      strb_q       <= strb_d;
      r1_q         <= r1_d;
      r2_q         <= r2_d;
      smp_we_q     <= smp_we_d;
      smp_addr_q   <= smp_addr_d;
      smp_data_q   <= smp_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign prng_ready = prng_ready_q;
  assign r1_valid   = strb_q;
  assign r2_valid   = strb_q;
  assign r1         = r1_q;
  assign r2         = r2_q;
  assign smp_we     = smp_we_q;
  assign smp_addr   = smp_addr_q;
  assign smp_data   = smp_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mkgauss_ctrl.sv
// Bench for mkgauss_ctrl: random PRNG/sampler stimulus, an event-level expectation model
// checked every cycle, and literal checks on the directed scenarios.
module tb_mkgauss_ctrl;

  localparam int unsigned LOGN_MAX = 10;
  localparam int unsigned TIMEOUT  = 2000;

  logic                clk = 1'b0;
  logic                rst_n, start, prng_valid, prng_ready;
  logic [3:0]          logn;
  logic [63:0]         prng_data, r1, r2;
  logic                r1_valid, r2_valid, val_valid, smp_we, busy, done, err;
  logic signed [31:0]  val;
  logic [LOGN_MAX-1:0] smp_addr;
  logic [31:0]         smp_data;

  mkgauss_ctrl #(.LOGN_MAX(LOGN_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .logn(logn),
    .prng_valid(prng_valid), .prng_data(prng_data), .prng_ready(prng_ready),
    .r1_valid(r1_valid), .r2_valid(r2_valid), .r1(r1), .r2(r2),
    .val_valid(val_valid), .val(val),
    .smp_we(smp_we), .smp_addr(smp_addr), .smp_data(smp_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Stimulus knobs
  bit          prng_rand = 1'b0;
  logic [63:0] next_word = 64'd0;
  int          rsp_mode  = 0;      // 0 respond, 2 never, 3 raise during the gap
  int          rsp_delay = 3;
  int          rsp_len   = 1;
  bit          rsp_rand  = 1'b0;
  logic [31:0] rsp_val   = 32'd0;

  // PRNG source: word advances only when consumed
  initial begin : prng_src
    bit took;
    prng_valid = 1'b0;
    prng_data  = 64'd0;
    forever begin
      @(negedge clk);
      took = prng_valid && prng_ready && rst_n;
      @(posedge clk); #1;
      if (took) next_word = next_word + 64'd1;
      prng_data  = next_word;
      prng_valid = prng_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // mkgauss stand-in: answers a configurable delay after beat B
  initial begin : responder
    bit rb, gap_raise;
    int cd, hold_left;
    val_valid = 1'b0; val = '0;
    rb = 1'b0; gap_raise = 1'b0; cd = -1; hold_left = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || done) begin
        rb = 1'b0; gap_raise = 1'b0; cd = -1; hold_left = 0;
      end else if (r1_valid) begin
        if (!rb) begin
          rb = 1'b1;
          if (rsp_mode == 3) gap_raise = 1'b1;
        end else begin
          rb = 1'b0;
          if (rsp_mode == 0) cd = rsp_rand ? int'($urandom_range(0, 12)) : rsp_delay;
        end
      end
      @(posedge clk); #1;
      if (gap_raise) begin
        gap_raise = 1'b0; val_valid = 1'b1; val = $urandom;
      end else if (hold_left > 0) begin
        hold_left--; val_valid = 1'b1;
      end else if (cd == 0) begin
        cd = -1; val_valid = 1'b1;
        val = rsp_rand ? $urandom : rsp_val;
        hold_left = rsp_len - 1;
      end else begin
        val_valid = 1'b0;
        if (cd > 0) cd--;
      end
    end
  end

  // Expectation model state (cycle numbers of expected events, -1 = none)
  int cyc = 0;
  bit m_busy, m_err, m_fetch, in_issue, waiting, drain_pend, first_a_pend;
  int m_fwords, m_n, m_idx;
  int exp_fetch = -1, exp_a = -1, exp_b = -1, exp_done = -1, exp_we = -1, tmo_cyc = -1, drain_from = -1;
  logic [31:0] exp_data;
  logic [63:0] wq[$];
  int words_run, writes_run, done_run = 0;
  int start_cyc, first_a_cyc, last_b_cyc, last_done_cyc, last_waddr;
  logic [63:0] a_r1, a_r2, b_r1, b_r2;
  logic [31:0] last_wdata;

  task automatic model_clear();
    m_busy = 1'b0; m_err = 1'b0; m_fetch = 1'b0; in_issue = 1'b0; waiting = 1'b0; drain_pend = 1'b0;
    exp_fetch = -1; exp_a = -1; exp_b = -1; exp_done = -1; exp_we = -1; tmo_cyc = -1;
    wq.delete();
  endtask

  always @(negedge clk) begin : monitor
    bit dn, is_a, is_b, ev_err, ev_start;
    logic [63:0] e1, e2;
    int lgv;
    cyc++;
    if (!rst_n) begin
      chk("reset_outputs", 64'({busy, done, err, prng_ready, r1_valid, r2_valid, smp_we,
                                |r1, |r2, |smp_addr, |smp_data}), 64'd0);
      model_clear();
    end else begin
      dn = (cyc == exp_done); ev_err = 1'b0; ev_start = 1'b0;
      chk("busy", 64'(busy), 64'(m_busy));
      chk("err", 64'(err), 64'(m_err));
      chk("done", 64'(done), 64'(dn));

      if (cyc == exp_fetch) begin m_fetch = 1'b1; m_fwords = 0; end
      chk("prng_ready", 64'(prng_ready), 64'(m_fetch));
      if (prng_valid && prng_ready) begin
        wq.push_back(prng_data);
        words_run++; m_fwords++;
        if (m_fwords == 4) begin m_fetch = 1'b0; exp_a = cyc + 1; end
      end

      if (waiting) begin
        if (val_valid) begin
          waiting = 1'b0; exp_we = cyc + 1; exp_data = val;
        end else if (cyc == tmo_cyc) begin
          waiting = 1'b0; ev_err = 1'b1; exp_done = cyc + 1;
        end
      end

      is_a = (cyc == exp_a); is_b = (cyc == exp_b);
      chk("strobe_pair", 64'(r2_valid), 64'(r1_valid));
      chk("strobe", 64'(r1_valid), 64'(is_a || is_b));
      if (is_a || is_b) begin
        if (wq.size() >= 2) begin
          e1 = wq.pop_front(); e2 = wq.pop_front();
          chk("beat_r1", r1, e1); chk("beat_r2", r2, e2);
        end else begin
          chk("beat_words_available", 64'(wq.size()), 64'd2);
        end
      end else begin
        chk("r1_idle_zero", r1, 64'd0); chk("r2_idle_zero", r2, 64'd0);
      end
      if (is_a) begin
        in_issue = 1'b1; exp_b = cyc + 2; a_r1 = r1; a_r2 = r2;
        if (first_a_pend) begin first_a_cyc = cyc; first_a_pend = 1'b0; end
      end
      if (in_issue && val_valid) begin
        in_issue = 1'b0; exp_b = -1; ev_err = 1'b1; exp_done = cyc + 1;
      end else if (is_b) begin
        in_issue = 1'b0; waiting = 1'b1; tmo_cyc = cyc + TIMEOUT;
        last_b_cyc = cyc; b_r1 = r1; b_r2 = r2;
      end

      chk("smp_we", 64'(smp_we), 64'(cyc == exp_we));
      if (cyc == exp_we) begin
        chk("smp_addr", 64'(smp_addr), 64'(m_idx));
        chk("smp_data", 64'(smp_data), 64'(exp_data));
        last_wdata = smp_data; last_waddr = int'(smp_addr);
        writes_run++; drain_pend = 1'b1; drain_from = cyc + 1;
      end
      if (drain_pend && cyc >= drain_from && !val_valid) begin
        drain_pend = 1'b0;
        if (m_idx == m_n - 1) exp_done = cyc + 1;
        else begin m_idx++; exp_fetch = cyc + 1; end
      end

      if (dn) begin done_run++; last_done_cyc = cyc; end
      if (start && !m_busy) ev_start = 1'b1;

      if (ev_err) m_err = 1'b1;
      if (dn) m_busy = 1'b0;
      if (ev_start) begin
        model_clear();
        m_busy = 1'b1;
        lgv = (int'(logn) > int'(LOGN_MAX)) ? int'(LOGN_MAX) : int'(logn);
        m_n = 1 << lgv; m_idx = 0; exp_fetch = cyc + 1;
        words_run = 0; writes_run = 0; start_cyc = cyc; first_a_pend = 1'b1;
      end
    end
  end

  task automatic pulse_start(input int lg);
    @(posedge clk); #1; start = 1'b1; logn = 4'(lg);
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0, input int budget);
    int i;
    i = 0;
    while (done_run == d0 && i < budget) begin @(posedge clk); i++; end
    #1;
    chk(name, 64'(done_run - d0), 64'd1);
  endtask

  initial begin : main
    int d0, i;
    rst_n = 1'b1; start = 1'b0; logn = 4'd0;
    #3 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_prng_ready", 64'(prng_ready), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Single sample, val = -7 ten cycles after beat B
    next_word = 64'd1; rsp_delay = 9; rsp_val = 32'hFFFF_FFF9;
    d0 = done_run; pulse_start(0); wait_done("single_done", d0, 200);
    chk("single_a_r1", a_r1, 64'd1); chk("single_a_r2", a_r2, 64'd2);
    chk("single_b_r1", b_r1, 64'd3); chk("single_b_r2", b_r2, 64'd4);
    chk("single_addr", 64'(last_waddr), 64'd0);
    chk("single_data", 64'(last_wdata), 64'hFFFF_FFF9);
    chk("start_to_beat_a", 64'(first_a_cyc - start_cyc), 64'd5);
    chk("single_writes", 64'(writes_run), 64'd1);
    chk("single_words", 64'(words_run), 64'd4);
    chk("single_err", 64'(err), 64'd0);

    // Full vector with PRNG stalls and an ignored second start
    prng_rand = 1'b1; rsp_rand = 1'b1; next_word = {$urandom, $urandom};
    d0 = done_run; pulse_start(3);
    repeat (30) @(posedge clk);
    #1; start = 1'b1; logn = 4'd0;
    @(posedge clk); #1; start = 1'b0;
    wait_done("full_done", d0, 3000);
    chk("full_writes", 64'(writes_run), 64'd8);
    chk("full_words", 64'(words_run), 64'd32);
    chk("full_err", 64'(err), 64'd0);
    repeat (20) @(posedge clk);
    chk("full_done_once", 64'(done_run - d0), 64'd1);

    // Multi-cycle valid
    prng_rand = 1'b0; rsp_rand = 1'b0; rsp_len = 4; rsp_val = 32'd123; rsp_delay = 2;
    d0 = done_run; pulse_start(1); wait_done("multi_done", d0, 300);
    chk("multi_writes", 64'(writes_run), 64'd2);
    chk("multi_data", 64'(last_wdata), 64'd123);

    // Timeout, then a fresh start clears err
    rsp_len = 1; rsp_mode = 2;
    d0 = done_run; pulse_start(0); wait_done("tmo_done", d0, TIMEOUT + 200);
    chk("tmo_err", 64'(err), 64'd1);
    chk("tmo_writes", 64'(writes_run), 64'd0);
    chk("tmo_latency", 64'(last_done_cyc - last_b_cyc), 64'(TIMEOUT + 1));
    rsp_mode = 0; rsp_delay = 4;
    d0 = done_run; pulse_start(0);
    chk("err_cleared", 64'(err), 64'd0);
    wait_done("after_tmo_done", d0, 200);
    chk("after_tmo_writes", 64'(writes_run), 64'd1);

    // val_valid during the gap
    rsp_mode = 3;
    d0 = done_run; pulse_start(2); wait_done("proto_done", d0, 200);
    chk("proto_err", 64'(err), 64'd1);
    chk("proto_writes", 64'(writes_run), 64'd0);

    // Reset during WAIT of the second sample
    rsp_mode = 0; rsp_delay = 30;
    pulse_start(2);
    i = 0;
    while (!(writes_run == 1 && waiting) && i < 300) begin @(posedge clk); i++; end
    chk("abort_reached_wait", 64'(writes_run == 1 && waiting), 64'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_outputs", 64'({busy, done, err, prng_ready, r1_valid, smp_we, |r1, |smp_data}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    rsp_delay = 5;
    d0 = done_run; pulse_start(0); wait_done("restart_done", d0, 200);
    chk("restart_addr", 64'(last_waddr), 64'd0);
    chk("restart_writes", 64'(writes_run), 64'd1);
    chk("restart_err", 64'(err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mkgauss_ctrl.md
# mkgauss_ctrl

Sequencer that drives the mkgauss discrete-Gaussian sampler for a full Falcon key-generation vector. On `start` it pulls 64-bit random words from the PRNG stream, issues them to mkgauss as two r1/r2 beats per sample with the required spacing, captures each signed sample, and writes it to the polynomial buffer at consecutive addresses until n = 2^logn samples are stored. It sits between the SHAKE-based PRNG and the f/g coefficient RAM.

## Interface
- `LOGN_MAX`, 10: largest supported log2(n); sets the address width.
- `TIMEOUT`, 2000: maximum cycles to wait for `val_valid` per sample.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request; honoured only in IDLE.
- `logn` in 4: log2 of sample count; sampled on accepted `start`.
- `prng_valid` in 1: PRNG word available.
- `prng_data` in 64: PRNG word.
- `prng_ready` out 1: controller consumes `prng_data` this cycle.
- `r1_valid`, `r2_valid` out 1: beat strobe to mkgauss; always equal.
- `r1`, `r2` out 64: random words to mkgauss.
- `val_valid` in 1: mkgauss sample valid.
- `val` in 32 signed: mkgauss sample.
- `smp_we` out 1: sample write strobe.
- `smp_addr` out LOGN_MAX: sample index.
- `smp_data` out 32: signed sample.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle end-of-run pulse.
- `err` out 1: sticky error flag.

## Operation
- States: IDLE, FETCH, ISSUE_A, GAP, ISSUE_B, WAIT, WRITE, DRAIN, DONE.
- IDLE: on `start`, latch n = 2^min(logn, LOGN_MAX) (logn=0 gives n=1), clear sample count and `err`, go to FETCH.
- FETCH: `prng_ready`=1 while fewer than 4 words are buffered; each cycle with `prng_valid`&`prng_ready` stores the next word as w0..w3 in arrival order. After w3, go to ISSUE_A.
- ISSUE_A: r1=w0, r2=w1, strobes high for exactly one cycle. GAP: strobes low for one cycle. ISSUE_B: r1=w2, r2=w3, strobes high for one cycle. Then WAIT.
- WAIT: the cycle counter starts at 0. On the first cycle `val_valid`=1, register `val` and go to WRITE. If the counter reaches TIMEOUT, set `err` and go to DONE without writing.
- WRITE: `smp_we`=1 for one cycle with `smp_addr`=count and `smp_data`=the captured val. Then DRAIN.
- DRAIN: hold until `val_valid`=0. This ignores multi-cycle valid; only the first cycle is captured. Then, if count = n-1, go to DONE; otherwise increment count and go to FETCH.
- DONE: `done`=1 for one cycle, then IDLE.
- `val_valid`=1 in ISSUE_A, GAP, or ISSUE_B is a protocol error: set `err` and go to DONE.
- `start` is ignored when not in IDLE.
- `r1`/`r2` are driven 0 whenever the strobes are low.

## Timing
- Reset values: all outputs 0; state IDLE; word buffer, count and timers 0.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0, including a `smp_we` or `done` in progress. No partial completion.
- `busy`=1 from the cycle after the accepted `start` through the DONE cycle inclusive.
- Beat spacing is fixed: beat B is issued exactly 2 cycles after beat A.
- Minimum gap between `val_valid` falling and the next beat A is 5 cycles (DRAIN exit plus ≥4 FETCH cycles).
- With `prng_valid` held high, cycles from `start` to the first beat A = 5. From `val_valid` rise to `smp_we` = 1 cycle.
- PRNG stalls extend FETCH only. Issue and gap timing are never stretched.
- Exactly 4n PRNG words are consumed per successful run.

## Test plan
- Reset: drive `rst_n`=0 for 1 cycle -> every output 0. After release with `start`=0 for 10 cycles, outputs stay 0 and `prng_ready` stays 0.
- Single sample: logn=0, PRNG supplies 1,2,3,4, and a model returns `val`=-7 for 1 cycle 10 cycles after beat B. Required:
  - beat A r1=1 r2=2;
  - one idle cycle;
  - beat B r1=3 r2=4;
  - `smp_we` with addr 0, data 0xFFFFFFF9;
  - `done` pulse; `err`=0.
- Full vector: logn=3 with `prng_valid` toggling randomly -> 8 writes at addrs 0..7 in order, 32 words consumed, `done` once. A second `start` during the run is ignored.
- Multi-cycle valid: the model holds `val_valid`=1 with `val`=123 for 4 cycles -> exactly one write of 123, and the next FETCH starts only after `val_valid` falls.
- Timeout: the model never responds -> after 2000 WAIT cycles, `err`=1, `done` pulses, no write. The next `start` clears `err`.
- Protocol error and abort:
  - `val_valid` raised during GAP -> `err`=1 and `done`.
  - Separately, `rst_n` pulsed low during WAIT of sample 2 of a logn=2 run -> IDLE with all outputs 0. A new run then starts writing at addr 0.
